// File: rtl/blackjack_engine.sv
// 21-style round controller: deal, player turn, automatic dealer turn,
// outcome resolution and saturating session tallies over a card valid/req handshake.
module blackjack_engine #(
  parameter int CARD_W       = 4,
  parameter int MAX_CARD     = 10,
  parameter int SCORE_W      = 6,
  parameter int TARGET       = 21,
  parameter int DEALER_STAND = 17,
  parameter int CNT_W        = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               hit,
  input  logic               stand,
  input  logic               card_valid,
  input  logic [CARD_W-1:0]  card_in,
  output logic               card_req,
  output logic [SCORE_W-1:0] player_score,
  output logic [SCORE_W-1:0] dealer_score,
  output logic [CARD_W-1:0]  last_card,
  output logic [1:0]         turn,
  output logic [2:0]         outcome,
  output logic [CNT_W-1:0]   wins,
  output logic [CNT_W-1:0]   losses,
  output logic [CNT_W-1:0]   pushes,
  output logic               busy
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DEAL_P1 = 4'd1;
  localparam logic [3:0] S_DEAL_D1 = 4'd2;
  localparam logic [3:0] S_DEAL_P2 = 4'd3;
  localparam logic [3:0] S_PLAYER  = 4'd4;
  localparam logic [3:0] S_P_DRAW  = 4'd5;
  localparam logic [3:0] S_DEALER  = 4'd6;
  localparam logic [3:0] S_D_DRAW  = 4'd7;
  localparam logic [3:0] S_RESOLVE = 4'd8;

  localparam logic [2:0] OC_WIN        = 3'b001;
  localparam logic [2:0] OC_LOSE       = 3'b010;
  localparam logic [2:0] OC_PUSH       = 3'b011;
  localparam logic [2:0] OC_WIN_DBUST  = 3'b101;
  localparam logic [2:0] OC_LOSE_PBUST = 3'b110;

  localparam logic [SCORE_W-1:0] TGT       = SCORE_W'(TARGET);
  localparam logic [SCORE_W-1:0] STAND_LIM = SCORE_W'(DEALER_STAND);
  localparam logic [CARD_W-1:0]  CARD_MAX  = CARD_W'(MAX_CARD);

  logic [3:0]         state;
  logic               start_q, hit_q, stand_q;
  logic               start_ev, hit_ev, stand_ev;
  logic [CARD_W-1:0]  card_val;
  logic [SCORE_W-1:0] player_next, dealer_next;

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [CARD_W-1:0]  b);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(b);
    return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  assign start_ev = start & ~start_q;
  assign hit_ev   = hit & ~hit_q;
  assign stand_ev = stand & ~stand_q;

  always_comb begin
    card_val = card_in;
    if (card_in == '0)
      card_val = CARD_W'(1);
    else if (card_in > CARD_MAX)
      card_val = CARD_MAX;
  end

  assign player_next = sat_add(player_score, card_val);
  assign dealer_next = sat_add(dealer_score, card_val);

  always_comb begin
    card_req = 1'b0;
    turn     = 2'b10;
    case (state)
      S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_P_DRAW: begin
        card_req = 1'b1;
        turn     = 2'b00;
      end
      S_PLAYER: turn = 2'b00;
      S_DEALER: turn = 2'b01;
      S_D_DRAW: begin
        card_req = 1'b1;
        turn     = 2'b01;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      start_q      <= 1'b0;
      hit_q        <= 1'b0;
      stand_q      <= 1'b0;
      player_score <= '0;
      dealer_score <= '0;
      last_card    <= '0;
      outcome      <= '0;
      wins         <= '0;
      losses       <= '0;
      pushes       <= '0;
    end else begin
      start_q <= start;
      hit_q   <= hit;
      stand_q <= stand;
      case (state)
        S_IDLE: if (start_ev) begin
          player_score <= '0;
          dealer_score <= '0;
          outcome      <= '0;
          state        <= S_DEAL_P1;
        end
        S_DEAL_P1: if (card_valid) begin
          player_score <= player_next;
          last_card    <= card_val;
          state        <= S_DEAL_D1;
        end
        S_DEAL_D1: if (card_valid) begin
          dealer_score <= dealer_next;
          last_card    <= card_val;
          state        <= S_DEAL_P2;
        end
        S_DEAL_P2: if (card_valid) begin
          player_score <= player_next;
          last_card    <= card_val;
          state        <= (player_next == TGT) ? S_DEALER : S_PLAYER;
        end
        // stand is tested first so a simultaneous hit is dropped
        S_PLAYER: begin
          if (stand_ev)
            state <= S_DEALER;
          else if (hit_ev)
            state <= S_P_DRAW;
        end
        S_P_DRAW: if (card_valid) begin
          player_score <= player_next;
          last_card    <= card_val;
          if (player_next > TGT)
            state <= S_RESOLVE;
          else if (player_next == TGT)
            state <= S_DEALER;
          else
            state <= S_PLAYER;
        end
        S_DEALER: state <= (dealer_score >= STAND_LIM) ? S_RESOLVE : S_D_DRAW;
        S_D_DRAW: if (card_valid) begin
          dealer_score <= dealer_next;
          last_card    <= card_val;
          state        <= S_DEALER;
        end
        S_RESOLVE: begin
          if (player_score > TGT) begin
            outcome <= OC_LOSE_PBUST;
            losses  <= sat_inc(losses);
          end else if (dealer_score > TGT) begin
            outcome <= OC_WIN_DBUST;
            wins    <= sat_inc(wins);
          end else if (player_score > dealer_score) begin
            outcome <= OC_WIN;
            wins    <= sat_inc(wins);
          end else if (player_score < dealer_score) begin
            outcome <= OC_LOSE;
            losses  <= sat_inc(losses);
          end else begin
            outcome <= OC_PUSH;
            pushes  <= sat_inc(pushes);
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blackjack_engine.sv
// Scoreboard bench for blackjack_engine: a card-game reference model predicts each
// round's result; a negedge monitor feeds cards and checks rounds as they complete.
module tb_blackjack_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, hit = 1'b0, stand = 1'b0;
  logic       card_valid = 1'b0;
  logic [3:0] card_in = '0;
  logic       card_req, busy;
  logic [5:0] player_score, dealer_score;
  logic [3:0] last_card;
  logic [1:0] turn;
  logic [2:0] outcome;
  logic [7:0] wins, losses, pushes;

  blackjack_engine #(
    .CARD_W(4), .MAX_CARD(10), .SCORE_W(6), .TARGET(21), .DEALER_STAND(17), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .hit(hit), .stand(stand),
    .card_valid(card_valid), .card_in(card_in), .card_req(card_req),
    .player_score(player_score), .dealer_score(dealer_score), .last_card(last_card),
    .turn(turn), .outcome(outcome), .wins(wins), .losses(losses), .pushes(pushes),
    .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct { int oc; int p; int d; int w; int l; int pu; } exp_t;

  exp_t exp_q[$];
  int   src_q[$];
  int   rd_idx = 0;
  int   hold = 0;
  int   errors = 0, checks = 0;
  int   ew = 0, el = 0, ep = 0;

  function automatic int clampc(input int x);
    if (x == 0) return 1;
    if (x > 10) return 10;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: plays the round from the game rules given a deck and a
  // player policy "hit while total < thr".
  function automatic void model(input int deck[$], input int thr, output int used,
                                output int hits, output int need_stand,
                                output int p, output int d, output int oc);
    int idx;
    p = clampc(deck[0]) + clampc(deck[2]);
    d = clampc(deck[1]);
    idx = 3; hits = 0; need_stand = 0;
    if (p != 21) begin
      forever begin
        if (p >= thr) begin need_stand = 1; break; end
        hits++;
        p += clampc(deck[idx]); idx++;
        if (p >= 21) break;
      end
    end
    if (p <= 21)
      while (d < 17) begin d += clampc(deck[idx]); idx++; end
    if (p > 21)      oc = 6;
    else if (d > 21) oc = 5;
    else if (p > d)  oc = 1;
    else if (p < d)  oc = 2;
    else             oc = 3;
    used = idx;
  endfunction

  // Monitor / card source: all sampling and driving on the falling edge.
  initial begin : monitor
    int   prev_busy, prev_req, prev_valid;
    exp_t e;
    prev_busy = 0; prev_req = 0; prev_valid = 0;
    forever begin
      @(negedge clock);
      if (prev_req != 0 && prev_valid != 0 && !reset) begin
        if (rd_idx < src_q.size())
          check("last_card", int'(last_card), clampc(src_q[rd_idx]));
        rd_idx++;
      end
      if (prev_busy != 0 && !busy) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL round_end: got unexpected round completion, expected none queued");
        end else begin
          e = exp_q.pop_front();
          check("outcome", int'(outcome), e.oc);
          check("player_score", int'(player_score), e.p);
          check("dealer_score", int'(dealer_score), e.d);
          check("wins", int'(wins), e.w);
          check("losses", int'(losses), e.l);
          check("pushes", int'(pushes), e.pu);
        end
      end
      prev_busy  = int'(busy);
      prev_req   = int'(card_req);
      card_valid = (hold == 0) && card_req && (rd_idx < src_q.size()) &&
                   ($urandom_range(0, 3) != 0);
      card_in    = (rd_idx < src_q.size()) ? 4'(src_q[rd_idx]) : 4'($urandom_range(0, 15));
      prev_valid = int'(card_valid);
    end
  end

  task automatic pulse(input int which);
    @(negedge clock);
    case (which)
      0: hit = 1'b1;
      1: stand = 1'b1;
      2: start = 1'b1;
      default: begin hit = 1'b1; stand = 1'b1; end
    endcase
    @(negedge clock);
    hit = 1'b0; stand = 1'b0; start = 1'b0;
  endtask

  task automatic wait_player();
    int n = 0;
    do begin @(negedge clock); n++; end
    while (!(busy && turn == 2'b00 && !card_req) && n < 500);
    checks++;
    if (n >= 500) begin errors++; $display("FAIL wait_player: got timeout expected PLAYER turn"); end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clock); n++; end
    while (busy && n < 1000);
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL wait_idle: got timeout expected IDLE"); end
  endtask

  task automatic prepare(input int deck[$], input int thr, output int hits, output int need);
    int used, p, d, oc;
    exp_t e;
    model(deck, thr, used, hits, need, p, d, oc);
    for (int i = 0; i < used; i++) src_q.push_back(deck[i]);
    if (oc == 1 || oc == 5) ew = (ew < 255) ? ew + 1 : ew;
    else if (oc == 3)       ep = (ep < 255) ? ep + 1 : ep;
    else                    el = (el < 255) ? el + 1 : el;
    e = '{oc, p, d, ew, el, ep};
    exp_q.push_back(e);
  endtask

  task automatic play(input int deck[$], input int thr);
    int hits, need;
    prepare(deck, thr, hits, need);
    pulse(2);
    for (int i = 0; i < hits; i++) begin wait_player(); pulse(0); end
    if (need != 0) begin wait_player(); pulse(1); end
    wait_idle();
  endtask

  initial begin : main
    int hits, need, n;
    int deck[$];
    repeat (2) @(negedge clock);
    check("rst_card_req", int'(card_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_turn", int'(turn), 2);
    check("rst_outcome", int'(outcome), 0);
    check("rst_wins", int'(wins), 0);
    check("rst_player", int'(player_score), 0);
    reset = 1'b0;
    @(negedge clock);

    // normal win
    prepare('{10, 5, 9, 10, 3}, 0, hits, need);
    pulse(2);
    wait_player();
    check("win_deal_player", int'(player_score), 19);
    check("win_deal_dealer", int'(dealer_score), 5);
    check("win_deal_turn", int'(turn), 0);
    pulse(1);
    wait_idle();
    check("win_end_turn", int'(turn), 2);

    // player bust: no further card requests afterwards
    play('{10, 6, 8, 5}, 20);
    repeat (3) begin @(negedge clock); check("bust_card_req", int'(card_req), 0); end

    // dealer bust, then push with clamped cards
    play('{10, 6, 9, 10, 9}, 0);
    play('{15, 10, 0, 9, 10}, 12);

    // valid withheld in P_DRAW, then simultaneous hit+stand
    prepare('{5, 6, 5, 4, 10, 2}, 11, hits, need);
    pulse(2);
    wait_player();
    check("hs_deal_player", int'(player_score), 10);
    hold = 1;
    pulse(0);
    repeat (5) begin
      @(negedge clock);
      check("hold_card_req", int'(card_req), 1);
      check("hold_player", int'(player_score), 10);
    end
    hold = 0;
    wait_player();
    check("hs_after_hit", int'(player_score), 14);
    pulse(3);
    check("both_turn_dealer", int'(turn), 1);
    check("both_player", int'(player_score), 14);
    wait_idle();

    // hit held high draws once; start while busy ignored
    prepare('{2, 3, 2, 3, 10, 5}, 5, hits, need);
    pulse(2);
    wait_player();
    check("held_deal_player", int'(player_score), 4);
    @(negedge clock); hit = 1'b1;
    wait_player();
    repeat (4) @(negedge clock);
    check("held_player", int'(player_score), 7);
    check("held_card_req", int'(card_req), 0);
    pulse(2);
    check("busy_start_turn", int'(turn), 0);
    check("busy_start_busy", int'(busy), 1);
    check("busy_start_player", int'(player_score), 7);
    check("busy_start_dealer", int'(dealer_score), 3);
    @(negedge clock); hit = 1'b0;
    pulse(1);
    wait_idle();

    // randomized rounds
    for (int r = 0; r < 24; r++) begin
      deck = {};
      for (int i = 0; i < 40; i++) deck.push_back($urandom_range(0, 15));
      play(deck, $urandom_range(12, 21));
    end

    // reset in the middle of a dealer draw that is waiting for a card
    src_q.push_back(10); src_q.push_back(6); src_q.push_back(9);
    pulse(2);
    wait_player();
    pulse(1);
    n = 0;
    do begin @(negedge clock); n++; end while (!(turn == 2'b01 && card_req) && n < 100);
    check("ddraw_reached", int'(n < 100), 1);
    exp_q.push_back('{0, 0, 0, 0, 0, 0});
    ew = 0; el = 0; ep = 0;
    #2 reset = 1'b1;
    #1;
    check("arst_card_req", int'(card_req), 0);
    check("arst_player", int'(player_score), 0);
    check("arst_dealer", int'(dealer_score), 0);
    check("arst_outcome", int'(outcome), 0);
    check("arst_wins", int'(wins), 0);
    check("arst_losses", int'(losses), 0);
    check("arst_last_card", int'(last_card), 0);
    check("arst_turn", int'(turn), 2);
    check("arst_busy", int'(busy), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // tallies restart from zero
    play('{10, 5, 9, 10, 3}, 0);

    repeat (3) @(negedge clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
